// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file constants and write-back types.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // Write-back source index; also the encoding of the round-robin pointer.
    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } wb_src_e;

    // x0 is hardwired to zero: writes to it are dropped and it is never pending.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] r);
        return (r == ZERO_REG);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one saturating counter per architectural register,
// bumped when decode issues a writer and dropped when the write-back lands.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             set_valid,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0] set_rd,
    output logic                             set_ready,
    input  logic                             wr_en,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0] wr_rd,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0] rs1,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0] rs2,
    output logic                             busy1,
    output logic                             busy2
);
    import rv32i_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [CNT_W-1:0]    count [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                inc;
    logic                dec;

    // A full counter refuses new writers; x0 always accepts since it is never tracked.
    // A same-cycle decrement is deliberately ignored here to keep this path short.
    assign set_ready = is_zero_reg(set_rd) || (count[set_rd] != CNT_MAX);
    assign inc       = set_valid && set_ready && !is_zero_reg(set_rd);
    assign dec       = wr_en && !is_zero_reg(wr_rd);

    // Busy reads registered state only, matching when the register file write becomes visible.
    assign busy1 = (count[rs1] != CNT_ZERO);
    assign busy2 = (count[rs2] != CNT_ZERO);

    // Expand the single increment and decrement into one-hot per-register strobes.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (inc) begin
            inc_vec[set_rd] = 1'b1;
        end
        if (dec) begin
            dec_vec[wr_rd] = 1'b1;
        end
    end

    // Update each counter; inc and dec on the same register cancel, a dec at zero is absorbed.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                count[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    if (count[i] != CNT_MAX) begin
                        count[i] <= count[i] + 1'b1;
                    end
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    if (count[i] != CNT_ZERO) begin
                        count[i] <= count[i] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the single-write-port RV32I register file:
// round-robin arbitration between the ALU and load unit, a registered
// write port, and the pending-write scoreboard used by decode.
module regfile_wb_ctrl #(
    parameter int XLEN       = rv32i_pkg::XLEN,
    parameter int CNT_W      = 2,
    parameter int RESET_PRIO = 1
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             req0_valid,
    output logic                             req0_ready,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0] req0_rd,
    input  logic [XLEN-1:0]                  req0_data,
    input  logic                             req1_valid,
    output logic                             req1_ready,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0] req1_rd,
    input  logic [XLEN-1:0]                  req1_data,
    output logic [rv32i_pkg::REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]                  reg_data3,
    output logic                             reg_write,
    input  logic                             sb_set,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0] sb_set_rd,
    output logic                             sb_set_ready,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0] sb_rs1,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0] sb_rs2,
    output logic                             sb_busy1,
    output logic                             sb_busy2
);
    import rv32i_pkg::*;

    localparam wb_src_e PTR_RESET = (RESET_PRIO != 0) ? REQ_LOAD : REQ_ALU;

    wb_src_e               ptr;
    logic                  gnt0;
    logic                  gnt1;
    logic                  grant_any;
    logic [REG_ADDR_W-1:0] gnt_rd;
    logic [XLEN-1:0]       gnt_data;

    // Round-robin grant: a lone requester always wins, a tie goes to the pointer.
    // Only the valids and the pointer are looked at, never the payload.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt0 = (ptr == REQ_ALU);
            gnt1 = (ptr == REQ_LOAD);
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign grant_any  = gnt0 || gnt1;
    assign gnt_rd     = gnt1 ? req1_rd   : req0_rd;
    assign gnt_data   = gnt1 ? req1_data : req0_data;

    // After any grant the other requester becomes favoured; idle cycles leave it alone.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr <= PTR_RESET;
        end else if (gnt0) begin
            ptr <= REQ_LOAD;
        end else if (gnt1) begin
            ptr <= REQ_ALU;
        end
    end

    // Registered write port: a grant shows up one cycle later; writes to x0 are
    // consumed silently and address/data hold whenever nothing is written.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd        <= ZERO_REG;
            reg_data3 <= '0;
            reg_write <= 1'b0;
        end else begin
            reg_write <= 1'b0;
            if (grant_any && !is_zero_reg(gnt_rd)) begin
                rd        <= gnt_rd;
                reg_data3 <= gnt_data;
                reg_write <= 1'b1;
            end
        end
    end

    reg_scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .set_valid (sb_set),
        .set_rd    (sb_set_rd),
        .set_ready (sb_set_ready),
        .wr_en     (reg_write),
        .wr_rd     (rd),
        .rs1       (sb_rs1),
        .rs2       (sb_rs2),
        .busy1     (sb_busy1),
        .busy2     (sb_busy2)
    );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed steps followed by a
// randomized phase, all checked against a behavioural model of the
// arbitration, write port and pending-write counts.
module tb_regfile_wb_ctrl;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        CLK;
    logic        RST_N;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic [4:0]  rd;
    logic [31:0] reg_data3;
    logic        reg_write;
    logic        sb_set;
    logic [4:0]  sb_set_rd;
    logic        sb_set_ready;
    logic [4:0]  sb_rs1;
    logic [4:0]  sb_rs2;
    logic        sb_busy1;
    logic        sb_busy2;

    regfile_wb_ctrl #(
        .XLEN       (XLEN),
        .CNT_W      (CNT_W),
        .RESET_PRIO (1)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_rd      (req0_rd),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_rd      (req1_rd),
        .req1_data    (req1_data),
        .rd           (rd),
        .reg_data3    (reg_data3),
        .reg_write    (reg_write),
        .sb_set       (sb_set),
        .sb_set_rd    (sb_set_rd),
        .sb_set_ready (sb_set_ready),
        .sb_rs1       (sb_rs1),
        .sb_rs2       (sb_rs2),
        .sb_busy1     (sb_busy1),
        .sb_busy2     (sb_busy2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int proto_errs = 0;

    // Behavioural model state.
    int          m_ptr;
    logic        m_wr;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_cnt [32];
    int          m_winner;

    // Outputs sampled at the last check point.
    logic        obs_r0, obs_r1, obs_sready, obs_busy1, obs_busy2, obs_wr;
    logic [4:0]  obs_rd;
    logic [31:0] obs_data;

    function automatic int pickWinner();
        if (req0_valid && req1_valid) return m_ptr;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic modelReset();
        m_ptr  = 1;
        m_wr   = 1'b0;
        m_rd   = 5'd0;
        m_data = 32'd0;
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCycle();
        int   w;
        logic exp_sready;
        w = pickWinner();
        obs_r0     = req0_ready;
        obs_r1     = req1_ready;
        obs_sready = sb_set_ready;
        obs_busy1  = sb_busy1;
        obs_busy2  = sb_busy2;
        obs_wr     = reg_write;
        obs_rd     = rd;
        obs_data   = reg_data3;
        exp_sready = (sb_set_rd == 5'd0) || (m_cnt[sb_set_rd] != CNT_MAX);
        checkOutput("req0_ready", 32'(obs_r0), 32'(w == 0));
        checkOutput("req1_ready", 32'(obs_r1), 32'(w == 1));
        checkOutput("sb_set_ready", 32'(obs_sready), 32'(exp_sready));
        checkOutput("sb_busy1", 32'(obs_busy1), 32'(m_cnt[sb_rs1] != 0));
        checkOutput("sb_busy2", 32'(obs_busy2), 32'(m_cnt[sb_rs2] != 0));
        checkOutput("reg_write", 32'(obs_wr), 32'(m_wr));
        if (m_wr) begin
            checkOutput("rd", 32'(obs_rd), 32'(m_rd));
            checkOutput("reg_data3", obs_data, m_data);
        end
    endtask

    task automatic modelEdge();
        int   w;
        logic inc, dec;
        w   = pickWinner();
        inc = sb_set && (sb_set_rd != 5'd0) && (m_cnt[sb_set_rd] != CNT_MAX);
        dec = m_wr && (m_rd != 5'd0);
        if (dec && m_cnt[m_rd] == 0) proto_errs++;
        if (!(inc && dec && sb_set_rd == m_rd)) begin
            if (inc) m_cnt[sb_set_rd]++;
            if (dec && m_cnt[m_rd] > 0) m_cnt[m_rd]--;
        end
        m_winner = w;
        if (w == 0) begin
            m_wr = (req0_rd != 5'd0);
            if (req0_rd != 5'd0) begin
                m_rd   = req0_rd;
                m_data = req0_data;
            end
            m_ptr = 1;
        end else if (w == 1) begin
            m_wr = (req1_rd != 5'd0);
            if (req1_rd != 5'd0) begin
                m_rd   = req1_rd;
                m_data = req1_data;
            end
            m_ptr = 0;
        end else begin
            m_wr = 1'b0;
        end
    endtask

    task automatic driveIdle();
        req0_valid = 1'b0; req0_rd = 5'd0; req0_data = 32'd0;
        req1_valid = 1'b0; req1_rd = 5'd0; req1_data = 32'd0;
        sb_set = 1'b0; sb_set_rd = 5'd0; sb_rs1 = 5'd0; sb_rs2 = 5'd0;
    endtask

    // One clock cycle: drive on the falling edge, check just after, advance the model on the rising edge.
    task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic s, input logic [4:0] srd,
                                 input logic [4:0] r1, input logic [4:0] r2);
        @(negedge CLK);
        req0_valid = v0; req0_rd = a0; req0_data = d0;
        req1_valid = v1; req1_rd = a1; req1_data = d1;
        sb_set = s; sb_set_rd = srd; sb_rs1 = r1; sb_rs2 = r2;
        #1;
        checkCycle();
        @(posedge CLK);
        modelEdge();
    endtask

    task automatic idleCycle(input logic [4:0] srd, input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, srd, r1, r2);
    endtask

    task automatic doReset();
        @(negedge CLK);
        driveIdle();
        RST_N = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_reg_write", 32'(reg_write), 32'd0);
        checkOutput("rst_rd", 32'(rd), 32'd0);
        checkOutput("rst_reg_data3", reg_data3, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    int          exp_order [4];
    logic        h0_v, h1_v;
    logic [4:0]  h0_rd, h1_rd;
    logic [31:0] h0_d, h1_d;

    initial begin
        RST_N = 1'b0;
        driveIdle();
        modelReset();
        m_winner = -1;
        doReset();

        // Step 1: idle after reset, sb_set_ready across every destination register.
        for (int i = 0; i < 32; i++) begin
            idleCycle(5'(i), 5'(i), 5'(31 - i));
            checkOutput("t1_set_ready", 32'(obs_sready), 32'd1);
        end

        // Step 2: lone ALU request, result appears one cycle later.
        applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        checkOutput("t2_req0_ready", 32'(obs_r0), 32'd1);
        idleCycle(5'd0, 5'd0, 5'd0);
        checkOutput("t2_rd", 32'(obs_rd), 32'd5);
        checkOutput("t2_data", obs_data, 32'h1234_5678);
        checkOutput("t2_wr", 32'(obs_wr), 32'd1);

        // Step 3: both requesters from reset, load side favoured first.
        doReset();
        exp_order = '{1, 0, 1, 0};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd4, 32'h0000_0444,
                          1'b0, 5'd0, 5'd0, 5'd0);
            checkOutput("t3_grant1", 32'(obs_r1), 32'(exp_order[k] == 1));
            checkOutput("t3_grant0", 32'(obs_r0), 32'(exp_order[k] == 0));
            if (k > 0) checkOutput("t3_rd", 32'(obs_rd), (exp_order[k-1] == 1) ? 32'd4 : 32'd3);
        end
        idleCycle(5'd0, 5'd0, 5'd0);
        checkOutput("t3_rd_last", 32'(obs_rd), 32'd3);

        // Step 4: saturate x7 then drain it with three write-backs.
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
        idleCycle(5'd7, 5'd7, 5'd0);
        checkOutput("t4_full_ready", 32'(obs_sready), 32'd0);
        checkOutput("t4_full_busy", 32'(obs_busy1), 32'd1);
        for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 5'd7, 32'(k), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
        idleCycle(5'd0, 5'd7, 5'd0);
        checkOutput("t4_busy_last_wr", 32'(obs_busy1), 32'd1);
        idleCycle(5'd0, 5'd7, 5'd0);
        checkOutput("t4_drained", 32'(obs_busy1), 32'd0);

        // Step 5: issue and retire x9 on the same edge.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd9);
        applyStimulus(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd9);
        checkOutput("t5_wr_x9", 32'(obs_wr), 32'd1);
        idleCycle(5'd9, 5'd0, 5'd9);
        checkOutput("t5_busy_kept", 32'(obs_busy2), 32'd1);
        checkOutput("t5_ready_x9", 32'(obs_sready), 32'd1);

        // Step 6: load write to x0, then asynchronous reset mid-stream.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd9, 5'd0);
        checkOutput("t6_req1_ready", 32'(obs_r1), 32'd1);
        idleCycle(5'd0, 5'd9, 5'd0);
        checkOutput("t6_x0_no_wr", 32'(obs_wr), 32'd0);
        checkOutput("t6_x9_still_busy", 32'(obs_busy1), 32'd1);
        applyStimulus(1'b1, 5'd10, 32'hABCD_0010, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge CLK);
        driveIdle();
        req0_valid = 1'b1; req0_rd = 5'd11; req0_data = 32'h0000_0B0B;
        #1;
        checkCycle();
        checkOutput("t6_wr_before_rst", 32'(obs_wr), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("t6_async_wr", 32'(reg_write), 32'd0);
        checkOutput("t6_async_rd", 32'(rd), 32'd0);
        checkOutput("t6_async_busy", 32'(sb_busy1), 32'd0);
        modelReset();
        driveIdle();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        applyStimulus(1'b1, 5'd11, 32'h0000_0B0B, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        checkOutput("t6_first_after_rel", 32'(obs_wr), 32'd0);
        idleCycle(5'd0, 5'd0, 5'd0);
        checkOutput("t6_x11_written", 32'(obs_rd), 32'd11);

        // Randomized phase: requesters obey the hold-until-ready rule.
        h0_v = 1'b0; h1_v = 1'b0;
        h0_rd = 5'd0; h1_rd = 5'd0; h0_d = 32'd0; h1_d = 32'd0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
                h0_v = 1'b0;
                h1_v = 1'b0;
            end
            if (!h0_v && $urandom_range(0, 99) < 55) begin
                h0_v = 1'b1; h0_rd = 5'($urandom_range(0, 12)); h0_d = $urandom;
            end
            if (!h1_v && $urandom_range(0, 99) < 55) begin
                h1_v = 1'b1; h1_rd = 5'($urandom_range(0, 12)); h1_d = $urandom;
            end
            applyStimulus(h0_v, h0_rd, h0_d, h1_v, h1_rd, h1_d,
                          1'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 12)),
                          5'($urandom_range(0, 12)), 5'($urandom_range(0, 12)));
            if (m_winner == 0) h0_v = 1'b0;
            else if (m_winner == 1) h1_v = 1'b0;
        end

        $display("[TB] write-backs seen with nothing pending: %0d", proto_errs);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
